// File: rtl/mem_write_tracer.sv
// mem_write_tracer: captures vector data-memory writes that fall inside an
// address window, queues them in a FIFO, and serialises each queued write
// into one trace beat per enabled lane, in ascending lane order.
//
// Optional feature (compile-time macro TRACE_CYCLE_STAMP_EN):
//   defined     - a free-running 32-bit cycle counter and per-entry stamp
//                 storage are built; trace_stamp_o carries the cycle stamp of
//                 the write that produced the beat.
//   not defined - neither is built and trace_stamp_o is tied to 0.
//
// Ports:
//   CLK                 in   system clock, rising edge
//   RST                 in   synchronous active-high reset
//   data_mem_WE_i       in   CPU data-memory write strobe
//   data_mem_address_i  in   base address of the write
//   data_mem_in_data_i  in   write data, lane k at [k*DATA_W +: DATA_W]
//   lane_mask_i         in   per-lane write enable
//   trace_ready_i       in   sink accepts the current beat
//   trace_valid_o       out  beat available
//   trace_addr_o        out  lane address (base + lane*LANE_STRIDE)
//   trace_data_o        out  lane data
//   trace_lane_o        out  lane index
//   trace_stamp_o       out  cycle stamp of the originating write
//   fifo_full_o         out  FIFO holds DEPTH entries
//   fifo_empty_o        out  FIFO holds no entries
//   drop_cnt_o          out  writes lost to overflow, saturating
module mem_write_tracer #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned LANE_STRIDE = 1,
    parameter logic [ADDR_W-1:0] WIN_LO = '0,
    parameter logic [ADDR_W-1:0] WIN_HI = '1,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     data_mem_WE_i,
    input  logic [ADDR_W-1:0]        data_mem_address_i,
    input  logic [LANES*DATA_W-1:0]  data_mem_in_data_i,
    input  logic [LANES-1:0]         lane_mask_i,
    input  logic                     trace_ready_i,
    output logic                     trace_valid_o,
    output logic [ADDR_W-1:0]        trace_addr_o,
    output logic [DATA_W-1:0]        trace_data_o,
    output logic [LANE_W-1:0]        trace_lane_o,
    output logic [31:0]              trace_stamp_o,
    output logic                     fifo_full_o,
    output logic                     fifo_empty_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Window test done as an offset compare so both bounds need only one comparator.
    localparam logic [ADDR_W:0] WIN_SPAN = {1'b0, WIN_HI - WIN_LO};

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    // Lowest set bit of a lane mask.
    function automatic logic [LANE_W-1:0] lowest_lane(input logic [LANES-1:0] m);
        lowest_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LANE_W-1:0] lane);
        lane_addr = base + ADDR_W'(lane) * ADDR_W'(LANE_STRIDE);
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input logic [VEC_W-1:0] vec,
                                                    input logic [LANE_W-1:0] lane);
        lane_data = vec[int'(lane) * int'(DATA_W) +: DATA_W];
    endfunction

    // FIFO storage and control
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [VEC_W-1:0]  data_mem [DEPTH];
    logic [LANES-1:0]  mask_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Serializer beat register (base address, full vector and mask of the entry in flight)
    state_t            state_q;
    logic [ADDR_W-1:0] beat_base_q;
    logic [VEC_W-1:0]  beat_vec_q;
    logic [LANES-1:0]  beat_mask_q;

    logic [ADDR_W:0]   win_off_c;
    logic              capture_c;
    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic [LANES-1:0]  rem_mask_c;
    logic              last_lane_c;
    logic [ADDR_W-1:0] head_addr_c;
    logic [VEC_W-1:0]  head_data_c;
    logic [LANES-1:0]  head_mask_c;
    logic [LANE_W-1:0] head_lane_c;
    logic [LANE_W-1:0] adv_lane_c;

    assign win_off_c = {1'b0, data_mem_address_i - WIN_LO};
    assign capture_c = data_mem_WE_i && (|lane_mask_i) && (win_off_c <= WIN_SPAN);
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    // Fullness is judged on the stored count, so a same-cycle pop never makes room.
    assign push_c    = capture_c && !full_c;

    // Lanes of the current entry still waiting to be emitted.
    always_comb begin
        rem_mask_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            rem_mask_c[i] = beat_mask_q[i] && (LANE_W'(i) > trace_lane_o);
        end
    end

    assign last_lane_c = ~|rem_mask_c;
    assign pop_c       = !empty_c &&
                         ((state_q == S_IDLE) ||
                          ((state_q == S_EMIT) && trace_ready_i && last_lane_c));

    assign head_addr_c = addr_mem[rd_ptr_q];
    assign head_data_c = data_mem[rd_ptr_q];
    assign head_mask_c = mask_mem[rd_ptr_q];
    assign head_lane_c = lowest_lane(head_mask_c);
    assign adv_lane_c  = lowest_lane(rem_mask_c);

    // FIFO payload write (no reset needed: contents are qualified by count)
    always_ff @(posedge CLK) begin
        if (push_c) begin
            addr_mem[wr_ptr_q] <= data_mem_address_i;
            data_mem[wr_ptr_q] <= data_mem_in_data_i;
            mask_mem[wr_ptr_q] <= lane_mask_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign fifo_full_o  = full_c;
    assign fifo_empty_o = empty_c;

    // Overflow drop counter, saturating
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_o <= '0;
        end else if (capture_c && full_c && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    // Serializer FSM: one beat per enabled lane, outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            trace_valid_o <= 1'b0;
            trace_addr_o  <= '0;
            trace_data_o  <= '0;
            trace_lane_o  <= '0;
            beat_base_q   <= '0;
            beat_vec_q    <= '0;
            beat_mask_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    trace_valid_o <= 1'b0;
                    if (pop_c) begin
                        state_q       <= S_EMIT;
                        trace_valid_o <= 1'b1;
                        beat_base_q   <= head_addr_c;
                        beat_vec_q    <= head_data_c;
                        beat_mask_q   <= head_mask_c;
                        trace_lane_o  <= head_lane_c;
                        trace_addr_o  <= lane_addr(head_addr_c, head_lane_c);
                        trace_data_o  <= lane_data(head_data_c, head_lane_c);
                    end
                end
                S_EMIT: begin
                    if (trace_ready_i) begin
                        if (!last_lane_c) begin
                            trace_lane_o <= adv_lane_c;
                            trace_addr_o <= lane_addr(beat_base_q, adv_lane_c);
                            trace_data_o <= lane_data(beat_vec_q, adv_lane_c);
                        end else if (pop_c) begin
                            beat_base_q  <= head_addr_c;
                            beat_vec_q   <= head_data_c;
                            beat_mask_q  <= head_mask_c;
                            trace_lane_o <= head_lane_c;
                            trace_addr_o <= lane_addr(head_addr_c, head_lane_c);
                            trace_data_o <= lane_data(head_data_c, head_lane_c);
                        end else begin
                            state_q       <= S_IDLE;
                            trace_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    trace_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] stamp_mem [DEPTH];

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c) stamp_mem[wr_ptr_q] <= cycle_q;
    end

    // Stamp only changes when a new entry is loaded into the beat register
    always_ff @(posedge CLK) begin
        if (RST) begin
            trace_stamp_o <= '0;
        end else if (pop_c) begin
            trace_stamp_o <= stamp_mem[rd_ptr_q];
        end
    end
`else
    assign trace_stamp_o = '0;
`endif

endmodule
